ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Owns RAM port B (4096×16, one-cycle registered read) and shares it between the CPU data bus, an auxiliary write-only requester (IR code logger / text-buffer writer) and a built-in clear engine. Replaces the ad-hoc clear counter and pass-through logic at the top level. The CPU is stalled through `cpu_wait` instead of clock gating. Peripheral address decode (110–113) stays outside; this block only sees RAM-bound accesses.

## Interface
Parameters:
- `ADDR_W`, 12, RAM address width
- `DATA_W`, 16, RAM word width
- `DEPTH`, 4096, words cleared by the clear engine (≤ 2^ADDR_W)
- `STARVE_LIM`, 3, consecutive aux denials before aux is forced

Ports:
- `clk`  in  1  system clock (50 MHz)
- `res`  in  1  reset, synchronous, active-low
- `cpu_sel`  in  1  CPU RAM access request, this cycle
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_rdata`  out  DATA_W  read data (= `ram_q`)
- `cpu_rvalid`  out  1  `cpu_rdata` valid this cycle
- `cpu_wait`  out  1  CPU access not accepted this cycle; CPU holds its request
- `clr_req`  in  1  start full-RAM clear (level sampled in IDLE)
- `clr_busy`  out  1  clear in progress
- `aux_req`  in  1  aux write pending; hold until ack
- `aux_addr`  in  ADDR_W  aux write address
- `aux_wdata`  in  DATA_W  aux write data
- `aux_ack`  out  1  aux write performed this cycle
- `ram_addr`  out  ADDR_W  port B address
- `ram_wdata`  out  DATA_W  port B write data
- `ram_we`  out  1  port B write enable
- `ram_q`  in  DATA_W  port B read data (one cycle after address)

## Operation
- States: IDLE, CLEAR. Reset → IDLE, clear counter 0, denial counter 0, read-pending flag 0.
- While `res` = 0: `ram_we`, `aux_ack`, `cpu_wait`, `cpu_rvalid`, `clr_busy` = 0; `ram_addr`/`ram_wdata` = 0.
- IDLE grant, per cycle, priority order:
  1. `clr_req`=1 and no CPU/aux grant this cycle → next state CLEAR.
  2. `aux_req` and denial counter = STARVE_LIM → aux granted; if `cpu_sel`, `cpu_wait`=1.
  3. `cpu_sel` → CPU granted (read or write).
  4. `aux_req` → aux granted.
- `clr_req` with a CPU or aux grant in the same cycle: access completes; CLEAR entered next cycle if `clr_req` still high. `clr_req` is level-sensitive; the requester deasserts it on seeing `clr_busy`.
- Denial counter: +1 when `aux_req` and CPU granted; cleared on aux grant or `aux_req`=0; saturates at STARVE_LIM.
- Granted write: `ram_addr`/`ram_wdata` from the grantee, `ram_we`=1. Aux grant → `aux_ack`=1 same cycle.
- Granted CPU read: `ram_we`=0; read-pending set; next cycle `cpu_rvalid`=1, `cpu_rdata`=`ram_q`.
- CLEAR: one write per cycle, `ram_addr`=counter, `ram_wdata`=0, `ram_we`=1. Counter 0…DEPTH−1; after DEPTH−1 → IDLE, counter 0. `cpu_wait`=1 whenever `cpu_sel`; `aux_ack`=0; `clr_req` ignored.
- Idle ungranted cycle: `ram_we`=0, `ram_addr` holds last value.

## Timing
- All grant outputs combinational from registered state plus current requests; no combinational path from `ram_q` into grant logic.
- Write latency 0 (written at the granted edge). Read latency 1 cycle.
- Clear: DEPTH write cycles (4096 = 81.92 µs). First write is in the cycle after CLEAR is entered. `clr_busy`=1 exactly during those cycles.
- Worst-case aux latency in IDLE: STARVE_LIM+1 cycles. Worst-case CPU wait: DEPTH+1 (clear) or 1 (starvation force).
- Reset mid-clear: IDLE at next edge, no further writes; RAM is left partially cleared.

## Structure
- Shared package `ram_bus_pkg`: `ADDR_W`, `DATA_W`, `DEPTH`, the state enum (IDLE, CLEAR), and the peripheral address constants 110–113 (used by the top-level decoder).
- Sub-module `ram_clear_counter`: counter with start/done, `ADDR_W`+1 bits wide so terminal detection does not wrap. The rest stays flat.

## Test plan
- CPU write 0x1234 to addr 5, read addr 5 next cycle → `ram_we` for 1 cycle; `cpu_rvalid`=1 one cycle after the read with `cpu_rdata`=0x1234; `cpu_wait` never asserted.
- `clr_req` pulse with memory pre-filled with 0xFFFF → `clr_busy` high for 4096 cycles, addresses 0…4095 in order with data 0; all RAM reads afterwards return 0.
- `cpu_sel` held continuously plus `aux_req` (addr 200, data 0xBEEF) → CPU granted 3 cycles, aux granted on cycle 4 with `aux_ack`=1 and `cpu_wait`=1, then CPU resumes.
- CPU read request during CLEAR → `cpu_wait`=1 until the cycle after the write to address 4095, then granted; `aux_ack` stays 0 throughout.
- `clr_req` and a CPU write in the same cycle → write lands, CLEAR starts the next cycle and overwrites the address with 0.
- `res`=0 at counter 1000 of a clear → next cycle `ram_we`=0, `clr_busy`=0; addresses ≥1000 keep their old data.

Source files
------------

// File: rtl/ram_bus_pkg.sv
//----------------------------------------------------------------------------
// ram_bus_pkg : shared RAM bus sizing, arbiter states, peripheral addresses
// Revision    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package ram_bus_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  // Peripheral window decoded at the top level; never reaches the arbiter.
  localparam int PERIPH_ADDR_0 = 110;
  localparam int PERIPH_ADDR_1 = 111;
  localparam int PERIPH_ADDR_2 = 112;
  localparam int PERIPH_ADDR_3 = 113;

endpackage

`default_nettype wire

// File: rtl/ram_clear_counter.sv
//----------------------------------------------------------------------------
// ram_clear_counter : clear address sequencer with start/done
// Revision          : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module ram_clear_counter #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              done_o
);

  // One extra bit so DEPTH == 2**ADDR_W still has a representable terminal.
  localparam int              CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_o  = en_i && (cnt_q == LAST);
  assign count_o = cnt_q[ADDR_W-1:0];

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = done_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
//----------------------------------------------------------------------------
// ram_port_arbiter : RAM port B sharing between CPU, aux writer, clear engine
// Revision         : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module ram_port_arbiter #(
  parameter int ADDR_W     = ram_bus_pkg::ADDR_W,
  parameter int DATA_W     = ram_bus_pkg::DATA_W,
  parameter int DEPTH      = ram_bus_pkg::DEPTH,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              res,
  input  logic              cpu_sel,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_wait,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  import ram_bus_pkg::*;

  localparam int               DENY_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [DENY_W-1:0] DENY_MAX = DENY_W'(STARVE_LIM);

  arb_state_t        state_q, state_d;
  logic [DENY_W-1:0] deny_q, deny_d;
  logic              rpend_q, rpend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              force_aux, aux_gnt, cpu_gnt;
  logic              clr_start, clr_en, clr_done;
  logic [ADDR_W-1:0] clr_addr;
  logic              we_w, wait_w, ack_w;
  logic [DATA_W-1:0] wdata_w;

  ram_clear_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_counter (
    .clk     (clk),
    .res     (res),
    .start_i (clr_start),
    .en_i    (clr_en),
    .count_o (clr_addr),
    .done_o  (clr_done)
  );

  always_comb begin
    state_d   = state_q;
    deny_d    = deny_q;
    rpend_d   = 1'b0;
    addr_d    = addr_q;
    force_aux = 1'b0;
    aux_gnt   = 1'b0;
    cpu_gnt   = 1'b0;
    clr_start = 1'b0;
    clr_en    = 1'b0;
    we_w      = 1'b0;
    wdata_w   = '0;
    wait_w    = 1'b0;
    ack_w     = 1'b0;

    case (state_q)
      IDLE: begin
        force_aux = aux_req && (deny_q == DENY_MAX);
        aux_gnt   = aux_req && (force_aux || !cpu_sel);
        cpu_gnt   = cpu_sel && !force_aux;
        wait_w    = cpu_sel && force_aux;

        if (aux_gnt) begin
          we_w    = 1'b1;
          addr_d  = aux_addr;
          wdata_w = aux_wdata;
          ack_w   = 1'b1;
        end else if (cpu_gnt) begin
          we_w    = cpu_we;
          addr_d  = cpu_addr;
          wdata_w = cpu_we ? cpu_wdata : '0;
          rpend_d = !cpu_we;
        end

        if (!aux_req || aux_gnt) begin
          deny_d = '0;
        end else if (cpu_gnt && (deny_q != DENY_MAX)) begin
          deny_d = deny_q + DENY_W'(1);
        end

        // A granted access this cycle defers the clear; clr_req is a level.
        if (clr_req && !aux_gnt && !cpu_gnt) begin
          state_d   = CLEAR;
          clr_start = 1'b1;
        end
      end

      CLEAR: begin
        clr_en  = 1'b1;
        we_w    = 1'b1;
        addr_d  = clr_addr;
        wait_w  = cpu_sel;
        if (!aux_req) begin
          deny_d = '0;
        end
        if (clr_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= IDLE;
      deny_q  <= '0;
      rpend_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      deny_q  <= deny_d;
      rpend_q <= rpend_d;
      addr_q  <= addr_d;
    end
  end

  // Everything the RAM or requesters see is forced quiet while in reset.
  assign ram_we     = res && we_w;
  assign ram_addr   = res ? addr_d : '0;
  assign ram_wdata  = res ? wdata_w : '0;
  assign cpu_wait   = res && wait_w;
  assign aux_ack    = res && ack_w;
  assign cpu_rvalid = res && rpend_q;
  assign clr_busy   = res && (state_q == CLEAR);
  assign cpu_rdata  = ram_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
//----------------------------------------------------------------------------
// tb_ram_port_arbiter : directed + random checks against a cycle-level model
// Revision            : 1.0
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ram_port_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 4096;
  localparam int LIM   = 3;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          cpu_sel = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid, cpu_wait;
  logic          clr_req = 1'b0;
  logic          clr_busy;
  logic          aux_req = 1'b0;
  logic [AW-1:0] aux_addr = '0;
  logic [DW-1:0] aux_wdata = '0;
  logic          aux_ack;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  always #10 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .STARVE_LIM(LIM)
  ) dut (
    .clk(clk), .res(res),
    .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_wait(cpu_wait),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_wdata(aux_wdata), .aux_ack(aux_ack),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
  );

  // Port-B RAM: registered read, preloaded with 0xFFFF on the first edge.
  logic          preload = 1'b1;
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 16'hFFFF;
    end else begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_q <= ram[ram_addr];
    end
  end

  // Reference model state.
  logic [DW-1:0] exp_mem [DEPTH];
  bit            m_clearing;
  int            m_cidx, m_deny;
  bit            m_rpend;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_last;
  bit            m_gaux, m_gcpu;
  logic          obs_ack, obs_wait, obs_busy, obs_rv;
  logic [DW-1:0] obs_rd;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_clearing = 0; m_cidx = 0; m_deny = 0; m_rpend = 0; m_last = '0;
  endtask

  task automatic step();
    logic          e_we, e_wait, e_ack, e_rv, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    @(negedge clk);
    m_gaux = 0; m_gcpu = 0;
    e_we = 0; e_wd = '0; e_wait = 0; e_ack = 0;
    e_addr = m_last; e_rv = m_rpend; e_busy = m_clearing;
    if (!res) begin
      e_addr = '0; e_rv = 0; e_busy = 0;
    end else if (m_clearing) begin
      e_we = 1; e_addr = AW'(m_cidx); e_wait = cpu_sel;
    end else begin
      if (aux_req && (m_deny == LIM || !cpu_sel)) m_gaux = 1;
      else if (cpu_sel) m_gcpu = 1;
      e_wait = cpu_sel && m_gaux;
      if (m_gaux) begin
        e_we = 1; e_addr = aux_addr; e_wd = aux_wdata; e_ack = 1;
      end else if (m_gcpu) begin
        e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
      end
    end
    obs_ack = aux_ack; obs_wait = cpu_wait; obs_busy = clr_busy;
    obs_rv = cpu_rvalid; obs_rd = cpu_rdata;
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
    if (!res) chk("ram_wdata_rst", 32'(ram_wdata), 32'h0);
    chk("cpu_wait", 32'(cpu_wait), 32'(e_wait));
    chk("aux_ack", 32'(aux_ack), 32'(e_ack));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_rv));
    chk("clr_busy", 32'(clr_busy), 32'(e_busy));
    if (e_rv) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
    @(posedge clk);
    if (!res) begin
      model_reset();
    end else begin
      m_rpend = m_gcpu && !cpu_we;
      if (m_rpend) m_rdata = exp_mem[cpu_addr];
      if (e_we) exp_mem[e_addr] = e_wd;
      if (e_we || m_gcpu) m_last = e_addr;
      if (m_clearing) begin
        m_cidx++;
        if (m_cidx == DEPTH) begin m_clearing = 0; m_cidx = 0; end
        if (!aux_req) m_deny = 0;
      end else begin
        if (!aux_req || m_gaux) m_deny = 0;
        else if (m_gcpu && m_deny < LIM) m_deny++;
        if (clr_req && !m_gaux && !m_gcpu) m_clearing = 1;
      end
    end
    #1;
  endtask

  task automatic cpu_drive(input logic sel, input logic we, input int addr, input logic [DW-1:0] d);
    cpu_sel = sel; cpu_we = we; cpu_addr = AW'(addr); cpu_wdata = d;
  endtask

  initial begin
    int  ack_at, n_busy, n_ack, k;
    bit  cpu_hold;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 16'hFFFF;
    model_reset();

    // Reset with requests active: outputs must stay quiet.
    res = 0; cpu_drive(1, 1, 9, 16'h1111); aux_req = 1; clr_req = 1;
    step(); preload = 0;
    step(); step();
    aux_req = 0; clr_req = 0; cpu_drive(0, 0, 0, 0);
    res = 1; step();

    // Write then read back.
    cpu_drive(1, 1, 5, 16'h1234); step(); chk("wr_wait", 32'(obs_wait), 0);
    cpu_drive(1, 0, 5, 16'h0);    step(); chk("rd_wait", 32'(obs_wait), 0);
    cpu_drive(0, 0, 0, 16'h0);    step();
    chk("rd_rvalid", 32'(obs_rv), 1);
    chk("rd_data", 32'(obs_rd), 32'h1234);

    // Starvation: CPU held, aux forced on the 4th cycle.
    cpu_drive(1, 1, 40, 16'h0042);
    aux_req = 1; aux_addr = 12'd200; aux_wdata = 16'hBEEF;
    ack_at = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (obs_ack && ack_at == 0) begin
        ack_at = c;
        chk("starve_wait", 32'(obs_wait), 1);
        aux_req = 0;
      end
    end
    chk("starve_ack_cycle", 32'(ack_at), 4);
    cpu_drive(1, 0, 200, 16'h0); step();
    cpu_drive(0, 0, 0, 16'h0);   step();
    chk("aux_data", 32'(obs_rd), 32'hBEEF);

    // CPU write coinciding with clr_req, then clear with CPU/aux waiting.
    cpu_drive(1, 1, 7, 16'hAAAA); clr_req = 1; step();
    chk("clr_not_yet", 32'(obs_busy), 0);
    cpu_drive(0, 0, 0, 16'h0); step();
    clr_req = 0;
    cpu_drive(1, 0, 7, 16'h0); aux_req = 1; aux_addr = 12'd300; aux_wdata = 16'h5555;
    n_busy = 0; n_ack = 0;
    for (k = 0; k < DEPTH + 10; k++) begin
      step();
      if (obs_ack) n_ack++;
      if (!obs_busy) break;
      n_busy++;
    end
    chk("clr_len", 32'(n_busy), 32'(DEPTH));
    chk("clr_no_ack", 32'(n_ack), 0);
    chk("post_clr_wait", 32'(obs_wait), 0);
    cpu_drive(0, 0, 0, 16'h0); step();
    chk("post_clr_rvalid", 32'(obs_rv), 1);
    chk("post_clr_data", 32'(obs_rd), 0);
    aux_req = 0;

    // Random traffic with occasional clears.
    cpu_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!cpu_hold)
        cpu_drive($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 31), DW'($urandom));
      if (!aux_req && $urandom_range(0, 3) == 0) begin
        aux_req = 1; aux_addr = AW'($urandom_range(0, 31)); aux_wdata = DW'($urandom);
      end
      if (!clr_req && $urandom_range(0, 699) == 0) clr_req = 1;
      step();
      cpu_hold = cpu_sel && obs_wait;
      if (obs_ack) aux_req = 0;
      if (obs_busy) clr_req = 0;
    end
    while (m_clearing && k < 20000) begin step(); k++; end
    aux_req = 0; clr_req = 0; cpu_drive(0, 0, 0, 16'h0); step();

    // Reset at clear count 1000 leaves upper RAM untouched.
    cpu_drive(1, 1, 1000, 16'h5A5A); step();
    cpu_drive(0, 0, 0, 16'h0); clr_req = 1; step(); clr_req = 0;
    k = 0;
    while (m_cidx < 1000 && k < 2000) begin step(); k++; end
    chk("mid_idx", 32'(m_cidx), 1000);
    res = 0; step();
    res = 1; step();
    chk("mid_busy", 32'(obs_busy), 0);
    cpu_drive(1, 0, 1000, 16'h0); step();
    cpu_drive(1, 0, 999, 16'h0);  step();
    chk("mid_keep", 32'(obs_rd), 32'h5A5A);
    cpu_drive(0, 0, 0, 16'h0);    step();
    chk("mid_cleared", 32'(obs_rd), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
